uart_tx_ctrl: RTL and testbench

UART transmit frame controller that sits directly upstream of the TX serializer and owns the serial line. It accepts a parallel byte with a valid strobe, hands it to the serializer with a one-cycle load pulse, and frames the serial bits as start, data, optional parity and stop. TX_OUT is the line driven by the TX top level. CLK is the transmit bit clock, one bit per cycle.

---
 rtl/uart_tx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a byte, loads the serializer and
// frames the line as start, data, optional parity and stop bits.
module uart_tx_ctrl #(
   parameter int Data_width = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [Data_width-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic                  ser_en,
   output logic [Data_width-1:0] ser_p_data,
   output logic                  TX_OUT,
   output logic                  Busy,
   output logic                  frame_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Count value on the last expected data bit; ser_done must show up by then.
   localparam logic [3:0] LAST_CNT = 4'(Data_width - 1);

   state_t      state_r;
   logic [3:0]  bit_cnt_r;
   logic        par_en_r;
   logic        par_bit_r;
   logic        accept_s;

   function automatic logic parity_of(input logic [Data_width-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   assign accept_s = DATA_VALID && ((state_r == IDLE) || (state_r == STOP));

   // Frame sequencing, request capture and serializer handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= IDLE;
         bit_cnt_r  <= 4'd0;
         par_en_r   <= 1'b0;
         par_bit_r  <= 1'b0;
         ser_en     <= 1'b0;
         ser_p_data <= '0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         ser_en    <= 1'b0;
         if (accept_s) begin
            ser_p_data <= P_DATA;
            par_en_r   <= PAR_EN;
            par_bit_r  <= parity_of(P_DATA, PAR_TYP);
            ser_en     <= 1'b1;
            state_r    <= START;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               START: begin
                  bit_cnt_r <= 4'd0;
                  state_r   <= DATA;
               end
               DATA: begin
                  if (bit_cnt_r != 4'hF) begin
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
                  if (ser_done) begin
                     state_r <= par_en_r ? PARITY : STOP;
                  end else if (bit_cnt_r == LAST_CNT) begin
                     // Serializer overran the frame: flag it and close without parity.
                     frame_err <= 1'b1;
                     state_r   <= STOP;
                  end else begin
                     state_r <= DATA;
                  end
               end
               PARITY: begin
                  state_r <= STOP;
               end
               STOP: begin
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   // Line and busy decode from the registered state.
   always_comb begin
      TX_OUT = 1'b1;
      Busy   = 1'b1;
      case (state_r)
         IDLE: begin
            TX_OUT = 1'b1;
            Busy   = 1'b0;
         end
         START:   TX_OUT = 1'b0;
         DATA:    TX_OUT = ser_data;
         PARITY:  TX_OUT = par_bit_r;
         STOP:    TX_OUT = 1'b1;
         default: begin
            TX_OUT = 1'b1;
            Busy   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle frame model plus a
// serializer model, with literal expectations for the directed frames.
module tb_uart_tx_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       ser_data;
   logic       ser_done;
   logic       ser_en;
   logic [7:0] ser_p_data;
   logic       TX_OUT;
   logic       Busy;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic done_mode = 1'b1;

   uart_tx_ctrl #(.Data_width(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
      .ser_en(ser_en), .ser_p_data(ser_p_data), .TX_OUT(TX_OUT), .Busy(Busy),
      .frame_err(frame_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Serializer model: load on ser_en, shift LSB first, done on the 8th bit.
   logic [7:0] s_reg;
   logic [3:0] s_cnt;
   logic       s_act;
   always @(posedge CLK) begin
      if (RST) begin
         s_act <= 1'b0;
         s_cnt <= 4'd0;
      end else if (ser_en) begin
         s_reg <= ser_p_data;
         s_cnt <= 4'd0;
         s_act <= 1'b1;
      end else if (s_act) begin
         if (s_cnt == 4'd7) s_act <= 1'b0;
         s_cnt <= s_cnt + 4'd1;
      end
   end
   assign ser_data = s_act ? s_reg[s_cnt[2:0]] : 1'b0;
   assign ser_done = s_act && (s_cnt == 4'd7) && done_mode;

   // Frame model: a queue of upcoming line cycles built when a request is taken.
   typedef struct {
      logic       tx;
      logic       en;
      logic       fe;
      logic       stp;
      logic [7:0] pd;
   } item_t;
   item_t q[$];

   function automatic item_t mk(logic tx, logic en, logic fe, logic stp, logic [7:0] pd);
      item_t it;
      it.tx = tx; it.en = en; it.fe = fe; it.stp = stp; it.pd = pd;
      return it;
   endfunction

   always @(posedge CLK) begin
      logic can_acc;
      logic par;
      if (RST) begin
         q.delete();
      end else begin
         can_acc = (q.size() == 0) || q[0].stp;
         if (q.size() > 0) void'(q.pop_front());
         if (can_acc && DATA_VALID) begin
            par = logic'($countones(P_DATA) % 2) ^ PAR_TYP;
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, P_DATA));
            for (int i = 0; i < 8; i++) q.push_back(mk(P_DATA[i], 1'b0, 1'b0, 1'b0, P_DATA));
            if (done_mode) begin
               if (PAR_EN) q.push_back(mk(par, 1'b0, 1'b0, 1'b0, P_DATA));
               q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, P_DATA));
            end else begin
               q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, P_DATA));
            end
         end
      end
   end

   // Compare DUT outputs against the model head every cycle.
   always @(negedge CLK) begin
      if (chk_en) begin
         if (q.size() == 0) begin
            chk("tx_idle", 32'(TX_OUT), 32'd1);
            chk("busy_idle", 32'(Busy), 32'd0);
            chk("ser_en_idle", 32'(ser_en), 32'd0);
            chk("frame_err_idle", 32'(frame_err), 32'd0);
         end else begin
            chk("tx", 32'(TX_OUT), 32'(q[0].tx));
            chk("busy", 32'(Busy), 32'd1);
            chk("ser_en", 32'(ser_en), 32'(q[0].en));
            chk("frame_err", 32'(frame_err), 32'(q[0].fe));
            if (q[0].en) chk("ser_p_data", 32'(ser_p_data), 32'(q[0].pd));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int len,
                       output logic [15:0] txv, output logic [15:0] bmask,
                       output logic [15:0] fmask);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      txv = 16'd0; bmask = 16'd0; fmask = 16'd0;
      for (int i = 0; i < len; i++) begin
         txv[i]   = TX_OUT;
         bmask[i] = Busy;
         fmask[i] = frame_err;
         @(negedge CLK);
      end
      chk("busy_after_frame", 32'(Busy), 32'd0);
   endtask

   initial begin
      logic [15:0] txv, bm, fm;
      logic [19:0] en_mask;
      int busy_cnt;
      RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk_en = 1'b1;
      chk("rst_ser_p_data", 32'(ser_p_data), 32'd0);
      chk("rst_tx", 32'(TX_OUT), 32'd1);
      @(negedge CLK);
      RST = 1'b0;
      repeat (20) @(negedge CLK);

      // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
      send(8'hA5, 1'b1, 1'b0, 11, txv, bm, fm);
      chk("a5_line", 32'(txv), 32'h054A);
      chk("a5_busy_cycles", 32'($countones(bm)), 32'd11);

      // 0x01 odd parity: parity bit 0
      send(8'h01, 1'b1, 1'b1, 11, txv, bm, fm);
      chk("01_odd_line", 32'(txv), 32'h0402);
      chk("01_odd_parity_bit", 32'(txv[9]), 32'd0);

      // 0x01 without parity: 10-cycle frame
      send(8'h01, 1'b0, 1'b0, 10, txv, bm, fm);
      chk("01_nopar_line", 32'(txv), 32'h0202);
      chk("01_nopar_busy_cycles", 32'($countones(bm)), 32'd10);

      // Back-to-back 0x55 then 0x0F with DATA_VALID held high
      @(negedge CLK);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      @(negedge CLK);
      P_DATA = 8'h0F;
      en_mask = 20'd0; busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         en_mask[i] = ser_en;
         busy_cnt += int'(Busy);
         if (i == 10) DATA_VALID = 1'b0;
         @(negedge CLK);
      end
      chk("b2b_ser_en_slots", 32'(en_mask), 32'h00401);
      chk("b2b_busy_cycles", 32'(busy_cnt), 32'd20);
      chk("b2b_idle_after", 32'(Busy), 32'd0);

      // Serializer never signals done: frame_err in the single STOP cycle
      done_mode = 1'b0;
      send(8'hC3, 1'b1, 1'b0, 11, txv, bm, fm);
      chk("nodone_frame_err", 32'(fm), 32'h0200);
      chk("nodone_busy", 32'(bm), 32'h03FF);
      done_mode = 1'b1;

      // Reset during data bit 3
      @(negedge CLK);
      P_DATA = 8'h5A; PAR_EN = 1'b0; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      chk("pre_rst_busy", 32'(Busy), 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
      chk("mid_rst_busy", 32'(Busy), 32'd0);
      chk("mid_rst_ser_en", 32'(ser_en), 32'd0);

      // New frame after reset: 0x3C even parity
      send(8'h3C, 1'b1, 1'b0, 11, txv, bm, fm);
      chk("post_rst_line", 32'(txv), 32'h0478);
      repeat (3) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
